// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage PC generator and its output buffer.
package fetch_pkg;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
        logic [31:0] pred_target;
    } fetch_pkt_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry fetch packet FIFO: slot0 is always the head, slot1 the younger entry.
// Occupancy is exposed as an enum state so checkers can bind to it directly.
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  fetch_pkt_t push_pkt,
    input  logic       pop,
    input  logic       flush,
    output fetch_pkt_t head_pkt,
    output buf_state_t count
);

    buf_state_t count_q, count_d;
    fetch_pkt_t slot0_q, slot0_d;
    fetch_pkt_t slot1_q, slot1_d;

    always_comb begin
        count_d = count_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (flush) begin
            count_d = BUF_EMPTY;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == BUF_EMPTY) begin
                        slot0_d = push_pkt;
                        count_d = BUF_ONE;
                    end else begin
                        slot1_d = push_pkt;
                        count_d = BUF_FULL;
                    end
                end
                2'b01: begin
                    // Younger entry shifts forward to become the head.
                    slot0_d = slot1_q;
                    count_d = (count_q == BUF_FULL) ? BUF_ONE : BUF_EMPTY;
                end
                2'b11: begin
                    if (count_q == BUF_ONE) begin
                        slot0_d = push_pkt;
                    end else begin
                        slot0_d = slot1_q;
                        slot1_d = push_pkt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= BUF_EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            count_q <= count_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign head_pkt = slot0_q;
    assign count    = count_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage PC register, next-PC selection (redirect > stall > predicted taken > PC+4)
// and predicted-target generation feeding a 2-entry buffer towards decode.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_if,
    input  logic [31:0] imem_rdata,
    input  logic        btb_hit,
    input  logic [31:0] btb_target,
    input  logic        pred_taken,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_pred_taken,
    output logic [31:0] out_pred_target
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] pred_target;
    logic        predict_taken;
    logic        fetch_en;
    logic        pop;
    logic [1:0]  count_bits;
    buf_state_t  count;
    fetch_pkt_t  push_pkt;
    fetch_pkt_t  head_pkt;
    logic        unused_low_bits;

    // Fetch addresses are word aligned, so the low target bits carry no information.
    assign unused_low_bits = ^{btb_target[1:0], redirect_pc[1:0]};

    assign count_bits    = count;
    assign fetch_en      = (count_bits < 2'(BUF_DEPTH)) & ~redirect_valid;
    assign out_valid     = (count != BUF_EMPTY);
    assign pop           = out_valid & out_ready & ~redirect_valid;
    assign predict_taken = btb_hit & pred_taken;
    assign pc_plus4      = pc_q + 32'(INSTR_BYTES);
    assign pred_target   = predict_taken ? {btb_target[31:2], 2'b00} : pc_plus4;

    always_comb begin
        push_pkt             = '0;
        push_pkt.pc          = pc_q;
        push_pkt.instr       = imem_rdata;
        push_pkt.pred_taken  = predict_taken;
        push_pkt.pred_target = pred_target;
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (fetch_en) begin
            pc_d = pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_skid_fifo u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fetch_en),
        .push_pkt (push_pkt),
        .pop      (pop),
        .flush    (redirect_valid),
        .head_pkt (head_pkt),
        .count    (count)
    );

    assign pc_if           = pc_q;
    assign out_pc          = head_pkt.pc;
    assign out_instr       = head_pkt.instr;
    assign out_pred_taken  = head_pkt.pred_taken;
    assign out_pred_target = head_pkt.pred_target;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed plus randomized bench for fetch_pc_unit with a queue-based reference of the buffer.
module tb_fetch_pc_unit;
    import fetch_pkg::*;

    localparam int PW = $bits(fetch_pkt_t);

    logic        clk;
    logic        rst;
    logic [31:0] pc_if;
    logic [31:0] imem_rdata;
    logic        btb_hit;
    logic [31:0] btb_target;
    logic        pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_pred_taken;
    logic [31:0] out_pred_target;

    int          n_checks;
    int          n_fail;
    logic [PW-1:0] exp_q[$];
    logic [31:0] m_pc;

    fetch_pc_unit dut (
        .clk             (clk),
        .rst             (rst),
        .pc_if           (pc_if),
        .imem_rdata      (imem_rdata),
        .btb_hit         (btb_hit),
        .btb_target      (btb_target),
        .pred_taken      (pred_taken),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .out_pred_taken  (out_pred_taken),
        .out_pred_target (out_pred_target)
    );

    // Clock / reset-free clock generator
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: combinational, content derived from the address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction
    assign imem_rdata = instr_of(pc_if);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the reference at negedge, advance the reference,
    // then let the edge happen and return 1 time unit after it.
    task automatic tick();
        fetch_pkt_t h;
        fetch_pkt_t p;
        logic       can_fetch;
        @(negedge clk);
        chk("pc_if", pc_if, m_pc);
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            chk("out_pc", out_pc, h.pc);
            chk("out_instr", out_instr, h.instr);
            chk("out_pred_taken", {31'd0, out_pred_taken}, {31'd0, h.pred_taken});
            chk("out_pred_target", out_pred_target, h.pred_target);
        end
        can_fetch = (exp_q.size() < 2) && !redirect_valid;
        if (rst) begin
            exp_q.delete();
            m_pc = DEFAULT_RESET_PC;
        end else if (redirect_valid) begin
            exp_q.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            if (can_fetch) begin
                p.pc          = m_pc;
                p.instr       = instr_of(m_pc);
                p.pred_taken  = btb_hit && pred_taken;
                p.pred_target = p.pred_taken ? {btb_target[31:2], 2'b00} : m_pc + 32'd4;
                exp_q.push_back(p);
                m_pc = p.pred_target;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; btb_hit = 1'b0; btb_target = '0; pred_taken = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc_if", pc_if, 32'h0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pred_taken", {31'd0, out_pred_taken}, 32'd0);
        chk("rst_out_pred_target", out_pred_target, 32'h0);
        m_pc = DEFAULT_RESET_PC;
        rst  = 1'b0;

        // Sequential fetch with decode always ready
        out_ready = 1'b1;
        repeat (6) tick();
        chk("seq_pc_if", pc_if, 32'h18);
        chk("seq_out_pc", out_pc, 32'h14);
        chk("seq_out_pred_target", out_pred_target, 32'h18);

        // Predicted-taken BTB hit at 0x40
        redirect_to(32'h40);
        chk("redir_pc_40", pc_if, 32'h40);
        btb_hit = 1'b1; pred_taken = 1'b1; btb_target = 32'h100;
        tick();
        btb_hit = 1'b0; pred_taken = 1'b0;
        chk("taken_pc_if", pc_if, 32'h100);
        chk("taken_out_pc", out_pc, 32'h40);
        chk("taken_out_pred", {31'd0, out_pred_taken}, 32'd1);
        chk("taken_out_tgt", out_pred_target, 32'h100);
        tick();

        // BTB hit but predicted not taken
        redirect_to(32'h40);
        btb_hit = 1'b1; pred_taken = 1'b0; btb_target = 32'h100;
        tick();
        btb_hit = 1'b0;
        chk("nt_pc_if", pc_if, 32'h44);
        chk("nt_out_pred", {31'd0, out_pred_taken}, 32'd0);
        chk("nt_out_tgt", out_pred_target, 32'h44);

        // Predictor taken without BTB hit counts as not taken
        pred_taken = 1'b1; btb_target = 32'h300;
        tick();
        pred_taken = 1'b0;
        chk("nohit_pc_if", pc_if, 32'h48);
        chk("nohit_out_tgt", out_pred_target, 32'h48);

        // Backpressure from empty: buffer fills to two, PC holds, head stable
        redirect_to(32'h0);
        out_ready = 1'b0;
        repeat (5) tick();
        chk("bp_pc_hold", pc_if, 32'h8);
        chk("bp_head_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        tick();
        chk("bp_drain1_pc", out_pc, 32'h4);
        chk("bp_drain1_pc_if", pc_if, 32'h8);
        tick();
        chk("bp_drain2_pc", out_pc, 32'h8);
        chk("bp_resume_pc_if", pc_if, 32'hC);

        // Redirect while full and decode ready: nothing delivered, buffer flushed
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        redirect_to(32'h203);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_pc_if", pc_if, 32'h200);
        tick();
        chk("flush_out_pc", out_pc, 32'h200);

        // Reset with a redirect while full
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
        tick();
        rst = 1'b0; redirect_valid = 1'b0;
        chk("mid_rst_pc_if", pc_if, 32'h0);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (4) tick();

        // Address wrap at the top of memory
        redirect_to(32'hFFFF_FFFC);
        tick();
        chk("wrap_pc_if", pc_if, 32'h0);
        chk("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
        chk("wrap_out_tgt", out_pred_target, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            btb_hit        = ($urandom_range(0, 3) == 0);
            pred_taken     = ($urandom_range(0, 1) == 1);
            btb_target     = $urandom();
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom();
            tick();
        end
        redirect_valid = 1'b0; btb_hit = 1'b0; pred_taken = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
